// File: rtl/carus_banked_sram_pkg.sv
// Shared types and constants for the banked SRAM controller and its per-bank slices.
package carus_banked_sram_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        RET_ENTRY = 2'd1,
        RETENTIVE = 2'd2,
        WAKEUP    = 2'd3
    } bank_state_e;

    localparam int DefaultWakeupCycles = 4;

    // Index widths never collapse to zero bits, even for a single bank.
    function automatic int clog2Min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/carus_sram_bank_ctrl.sv
// One SRAM bank: retention/wake state machine, wake settle counter and the macro itself.
module carus_sram_bank_ctrl
    import carus_banked_sram_pkg::*;
#(
    parameter  int NUM_WORDS     = 1024,
    parameter  int DATA_WIDTH    = 32,
    parameter  int WAKEUP_CYCLES = DefaultWakeupCycles,
    localparam int WordBits      = $clog2(NUM_WORDS),
    localparam int BeWidth       = DATA_WIDTH / 8,
    localparam int CntWidth      = clog2Min1(WAKEUP_CYCLES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sel_i,
    input  logic                  access_i,
    input  logic                  we_i,
    input  logic [WordBits-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BeWidth-1:0]    be_i,
    input  logic                  ret_req_i,
    output logic                  active_o,
    output logic                  ret_ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    bank_state_e         state_q;
    logic [CntWidth-1:0] wakeCnt_q;
    logic                retAck_q;
    logic                retN_q;

    // Ack and retention pin are registered alongside the state so they track RETENTIVE exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ACTIVE;
            wakeCnt_q <= '0;
            retAck_q  <= 1'b0;
            retN_q    <= 1'b1;
        end else begin
            retAck_q <= 1'b0;
            retN_q   <= 1'b1;
            unique case (state_q)
                ACTIVE: begin
                    if (ret_req_i && !sel_i) begin
                        state_q <= RET_ENTRY;
                    end
                end
                RET_ENTRY: begin
                    state_q  <= RETENTIVE;
                    retAck_q <= 1'b1;
                    retN_q   <= 1'b0;
                end
                RETENTIVE: begin
                    if (!ret_req_i || sel_i) begin
                        state_q   <= WAKEUP;
                        wakeCnt_q <= CntWidth'(WAKEUP_CYCLES - 1);
                    end else begin
                        retAck_q <= 1'b1;
                        retN_q   <= 1'b0;
                    end
                end
                WAKEUP: begin
                    if (wakeCnt_q == '0) begin
                        state_q <= ACTIVE;
                    end else begin
                        wakeCnt_q <= wakeCnt_q - CntWidth'(1);
                    end
                end
                default: state_q <= ACTIVE;
            endcase
        end
    end

    assign active_o  = (state_q == ACTIVE);
    assign ret_ack_o = retAck_q;

    sram_wrapper #(
        .NumWords (NUM_WORDS),
        .DataWidth(DATA_WIDTH)
    ) u_sram (
        .clk_i  (clk_i),
        .req_i  (access_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .be_i   (be_i),
        .ret_ni (retN_q),
        .rdata_o(rdata_o)
    );

endmodule

// File: rtl/sram_wrapper.sv
// Single-port SRAM macro with byte enables, registered read data and an active-low retention pin.
module sram_wrapper #(
    parameter  int NumWords  = 1024,
    parameter  int DataWidth = 32,
    localparam int AddrW     = $clog2(NumWords),
    localparam int BeW       = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrW-1:0]     addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeW-1:0]       be_i,
    input  logic                 ret_ni,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] rdata_q;

    // The array is frozen while the retention pin is low.
    always_ff @(posedge clk_i) begin
        if (req_i && ret_ni) begin
            if (we_i) begin
                for (int i = 0; i < BeW; i++) begin
                    if (be_i[i]) begin
                        mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/carus_banked_sram_ctrl.sv
// Banked SRAM front end: bank decode, combinational grant, and a one-cycle read return path.
module carus_banked_sram_ctrl
    import carus_banked_sram_pkg::*;
#(
    parameter  int NUM_BANKS     = 4,
    parameter  int NUM_WORDS     = 1024,
    parameter  int DATA_WIDTH    = 32,
    parameter  int WAKEUP_CYCLES = DefaultWakeupCycles,
    localparam int BankBits      = clog2Min1(NUM_BANKS),
    localparam int WordBits      = $clog2(NUM_WORDS),
    localparam int AddrWidth     = BankBits + WordBits,
    localparam int BeWidth       = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [AddrWidth-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BeWidth-1:0]    be_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic [NUM_BANKS-1:0]  ret_req_i,
    output logic [NUM_BANKS-1:0]  ret_ack_o
);

    logic [BankBits-1:0]   bankIdx;
    logic [NUM_BANKS-1:0]  bankActive;
    logic [DATA_WIDTH-1:0] bankRdata [NUM_BANKS];
    logic                  rvalid_q;
    logic [BankBits-1:0]   rBank_q;
    logic [DATA_WIDTH-1:0] rdataHold_q;

    assign bankIdx = addr_i[AddrWidth-1 -: BankBits];
    assign gnt_o   = rst_ni & req_i & bankActive[bankIdx];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gen_bank
        carus_sram_bank_ctrl #(
            .NUM_WORDS    (NUM_WORDS),
            .DATA_WIDTH   (DATA_WIDTH),
            .WAKEUP_CYCLES(WAKEUP_CYCLES)
        ) u_bank (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .sel_i    (req_i && (bankIdx == BankBits'(b))),
            .access_i (gnt_o && (bankIdx == BankBits'(b))),
            .we_i     (we_i),
            .addr_i   (addr_i[WordBits-1:0]),
            .wdata_i  (wdata_i),
            .be_i     (be_i),
            .ret_req_i(ret_req_i[b]),
            .active_o (bankActive[b]),
            .ret_ack_o(ret_ack_o[b]),
            .rdata_o  (bankRdata[b])
        );
    end

    // The bank of a granted read is remembered so its macro output can be steered out next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q    <= 1'b0;
            rBank_q     <= '0;
            rdataHold_q <= '0;
        end else begin
            rvalid_q <= gnt_o && !we_i;
            if (gnt_o && !we_i) begin
                rBank_q <= bankIdx;
            end
            if (rvalid_q) begin
                rdataHold_q <= bankRdata[rBank_q];
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rvalid_q ? bankRdata[rBank_q] : rdataHold_q;

endmodule

// File: tb/tb_carus_banked_sram_ctrl.sv
// Randomised bench for the banked SRAM controller, checked every cycle against a timestamp-based bank model.
module tb_carus_banked_sram_ctrl;

    localparam int NB = 4;
    localparam int NW = 1024;
    localparam int DW = 32;
    localparam int WC = 4;
    localparam int AW = 12;
    localparam int BW = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          req    = 1'b0;
    logic          we     = 1'b0;
    logic [AW-1:0] addr   = '0;
    logic [DW-1:0] wdata  = '0;
    logic [BW-1:0] be     = '0;
    logic [NB-1:0] retReq = '0;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [NB-1:0] retAck;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    carus_banked_sram_ctrl #(
        .NUM_BANKS(NB), .NUM_WORDS(NW), .DATA_WIDTH(DW), .WAKEUP_CYCLES(WC)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .be_i     (be),
        .rdata_o  (rdata),
        .rvalid_o (rvalid),
        .ret_req_i(retReq),
        .ret_ack_o(retAck)
    );

    // Model: a bank that decided to sleep at cycle d is unusable from d+1 and acked from d+2;
    // a wake decided at cycle t makes it usable again from t+1+WC.
    logic [DW-1:0] memModel [1 << AW];
    int            sleepDecision [NB];
    int            activeFrom [NB];
    int            cyc       = 0;
    logic          expRvalid = 1'b0;
    logic [DW-1:0] expRdata  = '0;
    logic          modelGnt  = 1'b0;
    logic          cmpOn     = 1'b0;

    function automatic int bankOf(input logic [AW-1:0] a);
        return int'(a[AW-1 -: 2]);
    endfunction

    function automatic logic [AW-1:0] mkAddr(input int bank, input int word);
        return AW'(bank * NW + word);
    endfunction

    function automatic logic bankAvail(input int b);
        return (sleepDecision[b] < 0) && (cyc >= activeFrom[b]);
    endfunction

    function automatic logic bankAsleep(input int b);
        return (sleepDecision[b] >= 0) && (cyc >= sleepDecision[b] + 2);
    endfunction

    function automatic logic expectGnt();
        return rst_n && req && bankAvail(bankOf(addr));
    endfunction

    task automatic modelReset();
        for (int b = 0; b < NB; b++) begin
            sleepDecision[b] = -1;
            activeFrom[b]    = 0;
        end
        expRvalid = 1'b0;
        expRdata  = '0;
        modelGnt  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge rst_n) modelReset();

    always @(posedge clk) begin : modelUpdate
        logic g;
        int   tgt;
        logic hit;
        if (rst_n) begin
            g   = expectGnt();
            tgt = bankOf(addr);
            if (g && we) begin
                for (int i = 0; i < BW; i++) begin
                    if (be[i]) memModel[addr][i*8 +: 8] = wdata[i*8 +: 8];
                end
            end
            expRvalid = g && !we;
            if (expRvalid) expRdata = memModel[addr];
            for (int b = 0; b < NB; b++) begin
                hit = req && (tgt == b);
                if (bankAvail(b)) begin
                    if (retReq[b] && !hit) sleepDecision[b] = cyc;
                end else if (bankAsleep(b)) begin
                    if (!retReq[b] || hit) begin
                        sleepDecision[b] = -1;
                        activeFrom[b]    = cyc + 1 + WC;
                    end
                end
            end
            modelGnt = g;
        end else begin
            modelGnt = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        logic [NB-1:0] expAck;
        if (cmpOn) begin
            for (int b = 0; b < NB; b++) expAck[b] = bankAsleep(b);
            checkOutput("gnt", gnt, expectGnt());
            checkOutput("rvalid", rvalid, expRvalid);
            checkOutput("rdata", rdata, expRdata);
            checkOutput("ret_ack", retAck, expAck);
        end
    end

    task automatic applyStimulus(input logic r, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [BW-1:0] e);
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        be    = e;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] e);
        applyStimulus(1'b1, w, a, d, e);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (modelGnt) break;
        end
        checkOutput("access_done", modelGnt, 1'b1);
        idle();
    endtask

    task automatic readLiteral(input string name, input logic [AW-1:0] a, input logic [DW-1:0] expData);
        applyStimulus(1'b1, 1'b0, a, '0, '0);
        @(negedge clk);
        checkOutput({name, "_gnt"}, gnt, 1'b1);
        tick();
        idle();
        @(negedge clk);
        checkOutput({name, "_rvalid"}, rvalid, 1'b1);
        checkOutput({name, "_rdata"}, rdata, expData);
        tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        modelReset();
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        #1 rst_n = 1'b0;
        cmpOn = 1'b1;
        @(negedge clk);
        checkOutput("reset_gnt", gnt, 1'b0);
        checkOutput("reset_rvalid", rvalid, 1'b0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_ack", retAck, 4'b0000);
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        access(1'b1, 12'h000, 32'hDEADBEEF, 4'hF);
        readLiteral("basic", 12'h000, 32'hDEADBEEF);

        access(1'b1, 12'h405, 32'h11223344, 4'hF);
        access(1'b1, 12'h405, 32'h000000AA, 4'h1);
        readLiteral("byte_en", 12'h405, 32'h112233AA);

        access(1'b1, 12'h803, 32'hCAFEF00D, 4'hF);

        // Bank 2 goes to sleep while bank 0 keeps streaming reads.
        applyStimulus(1'b1, 1'b0, 12'h000, '0, '0);
        retReq = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("sleep_bank0_gnt", gnt, 1'b1);
            if (k >= 1) checkOutput("sleep_bank0_rvalid", rvalid, 1'b1);
            checkOutput("sleep_ack", retAck, (k >= 2) ? 4'b0100 : 4'b0000);
            tick();
        end
        idle();

        // Demand wake of a sleeping bank with its retention request still held.
        applyStimulus(1'b1, 1'b0, 12'h803, '0, '0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt) break;
            n++;
            tick();
        end
        checkOutput("wake_wait_cycles", n, 1 + WC);
        tick();
        idle();
        @(negedge clk);
        checkOutput("wake_rvalid", rvalid, 1'b1);
        checkOutput("wake_rdata", rdata, 32'hCAFEF00D);
        tick();

        // Let bank 2 fall asleep again, start a wake, and reset in the middle of it.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (retAck[2]) break;
            tick();
        end
        checkOutput("resleep_ack", retAck, 4'b0100);
        tick();
        retReq = 4'b0000;
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 12'h405, '0, '0);
        rst_n = 1'b0;
        #1;
        checkOutput("midwake_reset_gnt", gnt, 1'b0);
        checkOutput("midwake_reset_rvalid", rvalid, 1'b0);
        checkOutput("midwake_reset_rdata", rdata, 32'h0);
        checkOutput("midwake_reset_ack", retAck, 4'b0000);
        tick();
        tick();
        idle();
        rst_n = 1'b1;
        for (int b = 0; b < NB; b++) begin
            applyStimulus(1'b1, 1'b1, mkAddr(b, 7), 32'h5A5A0000 + DW'(b), 4'hF);
            @(negedge clk);
            checkOutput("post_reset_gnt", gnt, 1'b1);
            tick();
        end
        idle();

        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < 8; w++) access(1'b1, mkAddr(b, w), $urandom, 4'hF);
        end

        // Alternate banks 0 and 3 every cycle: one read returned per cycle.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b0, mkAddr((k % 2) ? 3 : 0, (k / 2) % 8), '0, '0);
            @(negedge clk);
            checkOutput("alt_gnt", gnt, 1'b1);
            if (k > 0) checkOutput("alt_rvalid", rvalid, 1'b1);
            tick();
        end
        idle();
        @(negedge clk);
        checkOutput("alt_last_rvalid", rvalid, 1'b1);
        tick();

        for (int c = 0; c < 3000; c++) begin
            if (!req || modelGnt) begin
                if ($urandom_range(0, 3) != 0) begin
                    applyStimulus(1'b1, ($urandom_range(0, 2) == 0),
                                  mkAddr($urandom_range(0, 3), $urandom_range(0, 7)),
                                  $urandom, BW'($urandom_range(0, 15)));
                end else begin
                    idle();
                end
            end
            if ($urandom_range(0, 15) == 0) retReq[$urandom_range(0, 3)] ^= 1'b1;
            tick();
        end
        idle();
        retReq = '0;
        for (int i = 0; i < 12; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/carus_banked_sram_ctrl.md
CARUS_BANKED_SRAM_CTRL -- requirements
Module: carus_banked_sram_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 4, number of SRAM banks (power of two, >=1).
REQ-002 The block SHALL have parameter NUM_WORDS, default 1024, words per bank (power of two).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, word width (multiple of 8).
REQ-004 The block SHALL have parameter WAKEUP_CYCLES, default 4, retention-exit settle cycles (>=1).
REQ-005 The block SHALL have derived localparams BankBits=clog2(NUM_BANKS) (min 1), WordBits=clog2(NUM_WORDS), AddrWidth=BankBits+WordBits, BeWidth=DATA_WIDTH/8, none overridable.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-007 The block SHALL have port req_i  in  1  access request.
REQ-008 The block SHALL have port gnt_o  out  1  request accepted this cycle.
REQ-009 The block SHALL have port we_i  in  1  1=write, 0=read.
REQ-010 The block SHALL have port addr_i  in  AddrWidth  word address; MSBs select bank.
REQ-011 The block SHALL have port wdata_i  in  DATA_WIDTH  write data.
REQ-012 The block SHALL have port be_i  in  BeWidth  byte enables.
REQ-013 The block SHALL have port rdata_o  out  DATA_WIDTH  read data.
REQ-014 The block SHALL have port rvalid_o  out  1  rdata_o valid (reads only).
REQ-015 The block SHALL have port ret_req_i  in  NUM_BANKS  per-bank retention request.
REQ-016 The block SHALL have port ret_ack_o  out  NUM_BANKS  per-bank "in retention" status.

Function
REQ-017 Bank index SHALL be addr_i[AddrWidth-1 -: BankBits]; in-bank address SHALL be addr_i[WordBits-1:0].
REQ-018 Each bank SHALL run a 4-state FSM: ACTIVE, RET_ENTRY, RETENTIVE, WAKEUP.
REQ-019 ACTIVE->RET_ENTRY when ret_req_i[b]=1 and no request targets bank b that cycle; otherwise stay ACTIVE.
REQ-020 RET_ENTRY->RETENTIVE unconditionally after one cycle; bank refuses access in RET_ENTRY.
REQ-021 RETENTIVE->WAKEUP when ret_req_i[b]=0 OR req_i targets bank b (demand wake overrides ret_req_i).
REQ-022 WAKEUP SHALL load a counter with WAKEUP_CYCLES-1, decrement each cycle, go ACTIVE the cycle after it reads 0.
REQ-023 The bank macro retention pin SHALL be asserted (active-low, 0) only in RETENTIVE; ret_ack_o[b]=1 only in RETENTIVE.
REQ-024 gnt_o SHALL be combinational: gnt_o = req_i AND targeted bank in ACTIVE; no macro access without gnt_o.
REQ-025 Ungranted request: requester holds req_i/addr_i/we_i/wdata_i/be_i stable until gnt_o; block SHALL issue no macro access.
REQ-026 Granted write SHALL update only bytes with be_i set; no rvalid_o pulse.
REQ-027 Granted read SHALL give rvalid_o=1 exactly the next cycle with rdata_o from the bank captured at grant (registered bank select).
REQ-028 rdata_o SHALL hold its last valid value until the next rvalid_o; rvalid_o SHALL be a single-cycle pulse per read.
REQ-029 Back-to-back granted reads to any banks SHALL sustain one read per cycle (throughput 1).
REQ-030 A bank in WAKEUP then receiving ret_req_i=1 SHALL complete WAKEUP, reach ACTIVE, and then follow REQ-019.
REQ-031 Read latency with bank in RETENTIVE SHALL be 1+WAKEUP_CYCLES+1 cycles from req_i to rvalid_o.

Reset
REQ-032 On rst_ni=0 all bank FSMs SHALL go ACTIVE asynchronously, counters 0, rvalid_o=0, rdata_o=0, ret_ack_o=0, retention pins deasserted (1).
REQ-033 Reset mid-retention or mid-wakeup SHALL abort the sequence; memory contents are not guaranteed after reset.
REQ-034 gnt_o SHALL be 0 during reset regardless of req_i.

Structure
REQ-035 A shared package carus_banked_sram_pkg SHALL hold the bank-state enum (ACTIVE, RET_ENTRY, RETENTIVE, WAKEUP) and DefaultWakeupCycles constant.
REQ-036 The per-bank FSM, wake counter and macro instance SHALL be sub-module carus_sram_bank_ctrl, instantiated NUM_BANKS times via generate.
REQ-037 Each carus_sram_bank_ctrl SHALL instantiate the codebase sram_wrapper macro with NumWords=NUM_WORDS, DataWidth=DATA_WIDTH.

Verification
REQ-038 Write 0xDEADBEEF be=0xF to addr 0x000, read it -> gnt_o same cycle, rvalid_o next cycle, rdata_o=0xDEADBEEF.
REQ-039 Write 0x11223344 to bank1 word 5, then 0xAA be=0x1 -> read returns 0x112233AA.
REQ-040 ret_req_i=0b0100 idle -> bank2 RET_ENTRY 1 cycle, ret_ack_o=0b0100 next cycle; bank0 reads still granted every cycle.
REQ-041 Bank2 RETENTIVE, read bank2 with ret_req_i held -> gnt_o=0 for 1+WAKEUP_CYCLES cycles, then granted, rvalid_o next cycle, prior data intact.
REQ-042 Alternating reads bank0/bank3 every cycle -> rvalid_o high every cycle, data matches per-bank addresses.
REQ-043 Assert rst_ni=0 during WAKEUP -> all outputs at reset values immediately; all banks ACTIVE after release.
